// File: rtl/riscv_memarb.sv
// riscv_memarb: two-port arbiter sharing one pipelined memory/BIU request
// channel between instruction fetch (port 0) and data access (port 1).
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   clr_i              synchronous clear of pending tracking and lock
//   req_i/adr_i/size_i/lock_i/we_i/d_i   per-port upstream request
//   gnt_o              per-port grant (one-hot or zero), same cycle as req_i
//   ack_o, q_o         per-port completion routed by issue order, read data
//   req_o/adr_o/size_o/lock_o/we_o/d_o   downstream request channel
//   ack_i, q_i         downstream in-order completion and read data
//   idle_o             no access outstanding
//
// The arbiter keeps a small FIFO of the port id behind every issued access.
// Downstream acks arrive in issue order, so the FIFO head always names the
// port that the current ack belongs to.

package riscv_memarb_pkg;
  typedef logic [2:0] biu_size_t;
endpackage

module riscv_memarb
  import riscv_memarb_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MAX_PENDING = 2,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic [1:0]           req_i,
  input  logic [1:0][XLEN-1:0] adr_i,
  input  biu_size_t [1:0]      size_i,
  input  logic [1:0]           lock_i,
  input  logic [1:0]           we_i,
  input  logic [1:0][XLEN-1:0] d_i,
  output logic [1:0]           gnt_o,
  output logic [1:0]           ack_o,
  output logic [XLEN-1:0]      q_o,
  output logic                 req_o,
  output logic [XLEN-1:0]      adr_o,
  output biu_size_t            size_o,
  output logic                 lock_o,
  output logic                 we_o,
  output logic [XLEN-1:0]      d_o,
  input  logic                 ack_i,
  input  logic [XLEN-1:0]      q_i,
  output logic                 idle_o
);

  localparam int PW = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam int CW = $clog2(MAX_PENDING + 1);
  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_PENDING);
  localparam logic [PW-1:0] LAST_SLOT = PW'(MAX_PENDING - 1);

  // Tracking state
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic          id_q [MAX_PENDING];

  // Lock ownership and round-robin history
  logic lock_vld_q;
  logic lock_own_q;
  logic last_q;

  // Arbitration results
  logic       issue_ok;
  logic [1:0] elig;
  logic [1:0] gnt;
  logic       sel;
  logic       push;
  logic       pop;
  logic       head_id;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PW'(1);
  endfunction

  // Only the registered count gates issue; a same-cycle ack does not open a
  // slot, which keeps the grant path independent of ack_i timing.
  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    issue_ok = (count_q < MAX_CNT) && !clr_i;
    elig     = 2'b00;
    gnt      = 2'b00;
    // While a lock is held only its owner may be considered.
    elig[0]  = req_i[0] && issue_ok && (!lock_vld_q || !lock_own_q);
    elig[1]  = req_i[1] && issue_ok && (!lock_vld_q ||  lock_own_q);
    if (elig == 2'b11) begin
      if (ROUND_ROBIN != 0) begin
        gnt = last_q ? 2'b01 : 2'b10;
      end else begin
        gnt = 2'b01;
      end
    end else begin
      gnt = elig;
    end
  end

  // Granted port drives the channel; with no grant port 0 is selected.
  assign sel    = gnt[1];
  assign push   = |gnt;
  assign gnt_o  = gnt;
  assign req_o  = push;
  assign adr_o  = adr_i[sel];
  assign size_o = size_i[sel];
  assign lock_o = lock_i[sel];
  assign we_o   = we_i[sel];
  assign d_o    = d_i[sel];

  // An ack with nothing outstanding (e.g. straggler after clr_i) is dropped.
  assign head_id = id_q[rd_ptr_q];
  assign pop     = ack_i && (count_q != '0) && !clr_i;
  assign ack_o   = pop ? (head_id ? 2'b10 : 2'b01) : 2'b00;
  assign q_o     = q_i;
  assign idle_o  = (count_q == '0);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      lock_vld_q <= 1'b0;
      lock_own_q <= 1'b0;
      last_q     <= 1'b1;
      // NOTE: the id slots are tiny, so they are reset too; this keeps X
      // off the ack routing even though the count already masks stale slots.
      for (int i = 0; i < MAX_PENDING; i++) begin
        id_q[i] <= 1'b0;
      end
    end else if (clr_i) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      lock_vld_q <= 1'b0;
      lock_own_q <= 1'b0;
      last_q     <= 1'b1;
    end else begin
      count_q <= count_d;
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push) begin
        id_q[wr_ptr_q] <= sel;
        wr_ptr_q       <= ptr_inc(wr_ptr_q);
        last_q         <= sel;
        // A locked grant takes ownership; the owner's next unlocked grant
        // ends the sequence.
        if (lock_i[sel]) begin
          lock_vld_q <= 1'b1;
          lock_own_q <= sel;
        end else if (lock_vld_q && (lock_own_q == sel)) begin
          lock_vld_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/riscv_memarb.md
Name: riscv_memarb

Overview:
- Two-port arbiter that shares one pipelined memory/BIU request channel between the instruction-fetch path (port 0) and the data-access path (port 1).
- Each port sits downstream of its own memory access buffer.
- Selects one request per cycle, holds bus ownership across locked sequences, and records which port issued each outstanding access so that in-order acks and read data return to the right port.

Parameters:
- XLEN, 32, address/data width.
- MAX_PENDING, 2, max accesses in flight on the downstream channel (power of 2, >=1).
- ROUND_ROBIN, 1, 1 = round-robin on conflict; 0 = fixed priority, port 0 wins.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- clr_i  input  1  synchronous clear: drop all pending tracking, release lock.
- req_i  input  [2]  per-port request, held until granted.
- adr_i  input  [2][XLEN]  per-port address.
- size_i  input  biu_size_t[2]  per-port access size.
- lock_i  input  [2]  per-port lock (atomic sequence continues).
- we_i  input  [2]  per-port write enable.
- d_i  input  [2][XLEN]  per-port write data.
- gnt_o  output  [2]  request accepted this cycle (one-hot or zero).
- ack_o  output  [2]  per-port access completion.
- q_o  output  [XLEN]  read data, broadcast; valid for the port with ack_o set.
- req_o  output  1  downstream request.
- adr_o  output  XLEN  downstream address.
- size_o  output  biu_size_t  downstream size.
- lock_o  output  1  downstream lock.
- we_o  output  1  downstream write enable.
- d_o  output  XLEN  downstream write data.
- ack_i  input  1  downstream completion, in issue order.
- q_i  input  XLEN  downstream read data.
- idle_o  output  1  no access outstanding.

Behaviour:
- Reset / clr_i:
  - pending count = 0, id FIFO empty, lock owner none, last-grant = port 1.
  - Outputs: gnt_o=0, ack_o=0, req_o=0, idle_o=1.
- Issue condition: count < MAX_PENDING (registered count only; a same-cycle ack_i does not open a slot). If count == MAX_PENDING, gnt_o=0 and req_o=0.
- Arbitration is combinational, zero latency: gnt_o[p], req_o and the muxed adr/size/lock/we/d are all valid in the same cycle as req_i[p].
  - Both requesting, ROUND_ROBIN=1: grant the port that is not last-grant.
  - Both requesting, ROUND_ROBIN=0: grant port 0.
  - Single requester: granted whenever issue is allowed.
  - Downstream mux selects the granted port; when nothing is granted it selects port 0 (don't care, req_o=0).
- Lock:
  - A grant with lock_i=1 sets lock owner = that port.
  - While locked, only the owner may be granted; the other port is stalled regardless of ROUND_ROBIN.
  - The owner's next grant with lock_i=0 clears ownership at the clock edge.
  - lock_o = lock_i of the granted port.
- Tracking:
  - Each grant pushes the port id into a MAX_PENDING-deep FIFO and increments the count.
  - Each ack_i pops the head and decrements the count.
  - Grant and ack in the same cycle: count unchanged, push and pop both occur.
- Ack routing: ack_o[head_id] = ack_i (combinational); q_o = q_i.
  - ack_i with count == 0 (e.g. late ack after clr_i) is ignored: no ack_o, no count underflow.
- last-grant updates only on a grant.
- idle_o = (count == 0), registered-derived.
- Asynchronous reset asserted mid-operation: all state is cleared immediately and in-flight ids are lost. Upstream buffers must be reset together with this block.

Test Plan:
- Reset, then req_i=2'b01, adr_i[0]=0x100 -> same cycle gnt_o=01, req_o=1, adr_o=0x100; next cycle idle_o=0; ack_i -> ack_o=01, q_o=q_i, idle_o=1.
- ROUND_ROBIN=1, both ports requesting continuously, ack_i every cycle -> grants alternate 01,10,01,10 starting with port 0; ack_o follows the same sequence one or more cycles later.
- MAX_PENDING=2, port 1 requests 3 times with no ack -> gnt_o=10 twice, then 0 and req_o=0; one ack_i -> third grant issued the following cycle, not in the ack cycle.
- Port 1 issues lock_i=1 then lock_i=0 while port 0 requests throughout -> port 0 gets no grant until after the lock_i=0 grant; port 0 granted the next cycle.
- Out-of-order owners: grant p0, grant p1, then ack_i twice -> ack_o=01 then ack_o=10.
- Two accesses outstanding, clr_i pulse, then ack_i -> ack_o=0, idle_o=1, count remains 0; new request granted immediately.
